tdm_demux4: RTL and testbench

Time-division 1-to-4 demultiplexer; the receive-side inverse of the team's 4:1 mux.
- Accepts a serial stream of samples in slot order 00,01,10,11, with slot 00 marked by frame_start.
- Steers each sample to channel register a/b/c/d.
- Publishes a double-buffered, frame-aligned set of all four channels once per complete frame.
- Sits between a TDM link and per-channel consumers; tracks frame sync and flags misalignment.

---
 rtl/tdm_pkg.sv | 24 ++
 rtl/tdm_slot_ctr.sv | 24 ++
 rtl/tdm_demux4.sv | 133 +++++++++++++
 tb/tb_tdm_demux4.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 1-to-4 TDM receive demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] SLOT_A = 2'b00;
  localparam logic [1:0] SLOT_B = 2'b01;
  localparam logic [1:0] SLOT_C = 2'b10;
  localparam logic [1:0] SLOT_D = 2'b11;

  // One-hot channel strobe for a slot index.
  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [1:0] sl);
    logic [NUM_SLOTS-1:0] oh;
    oh     = '0;
    oh[sl] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index tracker: 2-bit wrap counter with clear and load-to-slot-01.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  input  logic       load1,
  input  logic       clr,
  output logic [1:0] s,
  output logic       last
);

  // Clear wins over load, load over advance; wrap is natural 2-bit overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     s <= SLOT_A;
    else if (clr)   s <= SLOT_A;
    else if (load1) s <= SLOT_B;
    else if (adv)   s <= s + 2'd1;
  end

  assign last = (s == SLOT_D);

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demux: per-slot capture, frame-aligned output bank, sync tracking.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  input  logic                 frame_start,
  output logic [W-1:0]         a,
  output logic [W-1:0]         b,
  output logic [W-1:0]         c,
  output logic [W-1:0]         d,
  output logic [NUM_SLOTS-1:0] ch_valid,
  output logic                 frame_valid,
  output logic [1:0]           s,
  output logic                 sync_err
);

  state_t state, state_nxt;

  logic [NUM_SLOTS-1:0][W-1:0] cap;

  logic       wr_en;
  logic [1:0] wr_slot;
  logic       err;
  logic       done;
  logic       ctr_adv, ctr_load1, ctr_clr;
  logic       last;

  tdm_slot_ctr u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (ctr_adv),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .s     (s),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  // Next state: lock on frame_start, drop back to HUNT when slot 00 lacks frame_start.
  always_comb begin
    state_nxt = state;
    if (din_valid) begin
      case (state)
        HUNT:    if (frame_start) state_nxt = RUN;
        RUN:     if (!frame_start && s == SLOT_A) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Per-sample decode: which capture slot to write, counter action, error and frame-done.
  // A misplaced frame_start restarts the frame at slot 00; the stale partial slots are
  // simply overwritten before the next completion, so nothing partial reaches the bank.
  always_comb begin
    wr_en     = 1'b0;
    wr_slot   = SLOT_A;
    err       = 1'b0;
    done      = 1'b0;
    ctr_adv   = 1'b0;
    ctr_load1 = 1'b0;
    ctr_clr   = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_start) begin
            wr_en     = 1'b1;
            ctr_load1 = 1'b1;
          end
        end
        RUN: begin
          if (frame_start && s != SLOT_A) begin
            err       = 1'b1;
            wr_en     = 1'b1;
            ctr_load1 = 1'b1;
          end else if (!frame_start && s == SLOT_A) begin
            err     = 1'b1;
            ctr_clr = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_slot = s;
            ctr_adv = 1'b1;
            done    = last;
          end
        end
        default: ;
      endcase
    end
  end

  // Capture registers, one per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_SLOTS; k++)
        if (wr_slot == 2'(k)) cap[k] <= din;
    end
  end

  // Output bank and strobes; slot 11 goes straight from din so the bank lands with ch_valid[3].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      ch_valid    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      ch_valid    <= wr_en ? slot_onehot(wr_slot) : '0;
      frame_valid <= done;
      sync_err    <= err;
      if (done) begin
        a <= cap[0];
        b <= cap[1];
        c <= cap[2];
        d <= din;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4 (W=8).
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [7:0] a, b, c, d;
  logic [3:0] ch_valid;
  logic       frame_valid;
  logic [1:0] s;
  logic       sync_err;

  logic [7:0]  st;
  logic [31:0] bk;
  logic [7:0]  exp_st;
  logic [31:0] exp_bk;
  int total = 0;
  int passed = 0;

  assign st = {ch_valid, frame_valid, sync_err, s};
  assign bk = {a, b, c, d};

  tdm_demux4 #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .a(a), .b(b), .c(c), .d(d),
    .ch_valid(ch_valid), .frame_valid(frame_valid), .s(s), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Apply one input cycle, then land 1 time unit after the edge that consumed it.
  task automatic drive(input logic v, input logic fs, input logic [7:0] x);
    din_valid = v; frame_start = fs; din = x;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    din_valid = 1'b0; frame_start = 1'b0; din = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (st !== 8'h00) $display("FAIL reset_strobes got=%b exp=%b", st, 8'h00); else passed++;
    total++; if (bk !== 32'h0) $display("FAIL reset_bank got=%h exp=%h", bk, 32'h0); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    drive(1, 1, 8'h11);
    exp_st = {4'b0001, 1'b0, 1'b0, 2'b01}; total++;
    if (st !== exp_st) $display("FAIL frame_slot0 got=%b exp=%b", st, exp_st); else passed++;
    drive(1, 0, 8'h22);
    exp_st = {4'b0010, 1'b0, 1'b0, 2'b10}; total++;
    if (st !== exp_st) $display("FAIL frame_slot1 got=%b exp=%b", st, exp_st); else passed++;
    drive(1, 0, 8'h33);
    exp_st = {4'b0100, 1'b0, 1'b0, 2'b11}; total++;
    if (st !== exp_st) $display("FAIL frame_slot2 got=%b exp=%b", st, exp_st); else passed++;
    total++; if (bk !== 32'h0) $display("FAIL frame_partial_bank got=%h exp=%h", bk, 32'h0); else passed++;
    drive(1, 0, 8'h44);
    exp_st = {4'b1000, 1'b1, 1'b0, 2'b00}; total++;
    if (st !== exp_st) $display("FAIL frame_slot3 got=%b exp=%b", st, exp_st); else passed++;
    exp_bk = 32'h11223344; total++;
    if (bk !== exp_bk) $display("FAIL frame_bank got=%h exp=%h", bk, exp_bk); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [8];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) begin
      drive(1, (i % 4) == 0, vals[i]);
      exp_st = {4'b0001 << (i % 4), ((i % 4) == 3), 1'b0, 2'((i + 1) % 4)}; total++;
      if (st !== exp_st) $display("FAIL b2b_step%0d got=%b exp=%b", i, st, exp_st); else passed++;
      if (i == 3) begin
        exp_bk = 32'h11223344; total++;
        if (bk !== exp_bk) $display("FAIL b2b_bank1 got=%h exp=%h", bk, exp_bk); else passed++;
      end
    end
    exp_bk = 32'h55667788; total++;
    if (bk !== exp_bk) $display("FAIL b2b_bank2 got=%h exp=%h", bk, exp_bk); else passed++;
  endtask

  task automatic test_hunt();
    do_reset();
    drive(1, 0, 8'hAA);
    total++; if (st !== 8'h00) $display("FAIL hunt_ignore_aa got=%b exp=%b", st, 8'h00); else passed++;
    drive(1, 0, 8'hBB);
    total++; if (st !== 8'h00) $display("FAIL hunt_ignore_bb got=%b exp=%b", st, 8'h00); else passed++;
    drive(1, 1, 8'h01);
    exp_st = {4'b0001, 1'b0, 1'b0, 2'b01}; total++;
    if (st !== exp_st) $display("FAIL hunt_lock got=%b exp=%b", st, exp_st); else passed++;
  endtask

  task automatic test_resync_mid();
    do_reset();
    drive(1, 1, 8'h01); drive(1, 0, 8'h02); drive(1, 0, 8'h03); drive(1, 0, 8'h04);
    exp_bk = 32'h01020304; total++;
    if (bk !== exp_bk) $display("FAIL resync_prior_bank got=%h exp=%h", bk, exp_bk); else passed++;
    drive(1, 1, 8'h11); drive(1, 0, 8'h22);
    drive(1, 1, 8'h99);
    exp_st = {4'b0001, 1'b0, 1'b1, 2'b01}; total++;
    if (st !== exp_st) $display("FAIL resync_err got=%b exp=%b", st, exp_st); else passed++;
    total++; if (bk !== exp_bk) $display("FAIL resync_bank_hold got=%h exp=%h", bk, exp_bk); else passed++;
    drive(1, 0, 8'hA2);
    exp_st = {4'b0010, 1'b0, 1'b0, 2'b10}; total++;
    if (st !== exp_st) $display("FAIL resync_slot1 got=%b exp=%b", st, exp_st); else passed++;
    drive(1, 0, 8'hA3);
    drive(1, 0, 8'hA4);
    exp_st = {4'b1000, 1'b1, 1'b0, 2'b00}; total++;
    if (st !== exp_st) $display("FAIL resync_done got=%b exp=%b", st, exp_st); else passed++;
    exp_bk = 32'h99A2A3A4; total++;
    if (bk !== exp_bk) $display("FAIL resync_bank got=%h exp=%h", bk, exp_bk); else passed++;
  endtask

  task automatic test_lost_sync();
    // Entered with s=00 in RUN, bank 99A2A3A4.
    drive(1, 0, 8'h55);
    exp_st = {4'b0000, 1'b0, 1'b1, 2'b00}; total++;
    if (st !== exp_st) $display("FAIL lost_err got=%b exp=%b", st, exp_st); else passed++;
    exp_bk = 32'h99A2A3A4; total++;
    if (bk !== exp_bk) $display("FAIL lost_bank_hold got=%h exp=%h", bk, exp_bk); else passed++;
    drive(1, 0, 8'h66);
    total++; if (st !== 8'h00) $display("FAIL lost_hunt_ignore got=%b exp=%b", st, 8'h00); else passed++;
    drive(1, 1, 8'h10);
    exp_st = {4'b0001, 1'b0, 1'b0, 2'b01}; total++;
    if (st !== exp_st) $display("FAIL lost_relock got=%b exp=%b", st, exp_st); else passed++;
    drive(1, 0, 8'h20); drive(1, 0, 8'h30); drive(1, 0, 8'h40);
    exp_st = {4'b1000, 1'b1, 1'b0, 2'b00}; total++;
    if (st !== exp_st) $display("FAIL lost_done got=%b exp=%b", st, exp_st); else passed++;
    exp_bk = 32'h10203040; total++;
    if (bk !== exp_bk) $display("FAIL lost_bank got=%h exp=%h", bk, exp_bk); else passed++;
  endtask

  task automatic test_gaps();
    do_reset();
    drive(1, 1, 8'h11);
    exp_st = {4'b0001, 1'b0, 1'b0, 2'b01}; total++;
    if (st !== exp_st) $display("FAIL gap_slot0 got=%b exp=%b", st, exp_st); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'hEE);
      exp_st = {4'b0000, 1'b0, 1'b0, 2'b01}; total++;
      if (st !== exp_st) $display("FAIL gap_idle%0d got=%b exp=%b", i, st, exp_st); else passed++;
    end
    drive(1, 0, 8'h22);
    exp_st = {4'b0010, 1'b0, 1'b0, 2'b10}; total++;
    if (st !== exp_st) $display("FAIL gap_slot1 got=%b exp=%b", st, exp_st); else passed++;
    drive(0, 0, 8'hEE);
    exp_st = {4'b0000, 1'b0, 1'b0, 2'b10}; total++;
    if (st !== exp_st) $display("FAIL gap_idle3 got=%b exp=%b", st, exp_st); else passed++;
    drive(1, 0, 8'h33);
    exp_st = {4'b0100, 1'b0, 1'b0, 2'b11}; total++;
    if (st !== exp_st) $display("FAIL gap_slot2 got=%b exp=%b", st, exp_st); else passed++;
    drive(1, 0, 8'h44);
    exp_st = {4'b1000, 1'b1, 1'b0, 2'b00}; total++;
    if (st !== exp_st) $display("FAIL gap_slot3 got=%b exp=%b", st, exp_st); else passed++;
    exp_bk = 32'h11223344; total++;
    if (bk !== exp_bk) $display("FAIL gap_bank got=%h exp=%h", bk, exp_bk); else passed++;
  endtask

  task automatic test_async_reset();
    drive(1, 1, 8'h11);
    drive(1, 0, 8'h22);
    exp_st = {4'b0010, 1'b0, 1'b0, 2'b10}; total++;
    if (st !== exp_st) $display("FAIL arst_pre got=%b exp=%b", st, exp_st); else passed++;
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (st !== 8'h00) $display("FAIL arst_strobes got=%b exp=%b", st, 8'h00); else passed++;
    total++; if (bk !== 32'h0) $display("FAIL arst_bank got=%h exp=%h", bk, 32'h0); else passed++;
    #1 rst_n = 1'b1;
    drive(1, 0, 8'h33);
    total++; if (st !== 8'h00) $display("FAIL arst_hunt got=%b exp=%b", st, 8'h00); else passed++;
    drive(1, 1, 8'h44);
    exp_st = {4'b0001, 1'b0, 1'b0, 2'b01}; total++;
    if (st !== exp_st) $display("FAIL arst_relock got=%b exp=%b", st, exp_st); else passed++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_hunt();
    test_resync_mid();
    test_lost_sync();
    test_gaps();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
